// File: rtl/csrng_blkenc_client_arb_if.sv
// Handshake and data bundle between the two CTR_DRBG clients, the arbiter
// and the AES block-encrypt engine. The slave view is the arbiter itself.
interface csrng_blkenc_client_arb_if #(
  parameter int Cmd     = 3,
  parameter int StateId = 4,
  parameter int BlkLen  = 128,
  parameter int KeyLen  = 256
);
  logic               enable_i;
  logic               c0_req_i;
  logic               c1_req_i;
  logic               c0_rdy_o;
  logic               c1_rdy_o;
  logic [KeyLen-1:0]  c0_key_i;
  logic [KeyLen-1:0]  c1_key_i;
  logic [BlkLen-1:0]  c0_v_i;
  logic [BlkLen-1:0]  c1_v_i;
  logic [Cmd-1:0]     c0_cmd_i;
  logic [Cmd-1:0]     c1_cmd_i;
  logic [StateId-1:0] c0_id_i;
  logic [StateId-1:0] c1_id_i;
  logic               c0_ack_o;
  logic               c1_ack_o;
  logic               c0_rdy_i;
  logic               c1_rdy_i;
  logic [BlkLen-1:0]  res_v_o;
  logic [Cmd-1:0]     res_cmd_o;
  logic [StateId-1:0] res_id_o;
  logic               benc_req_o;
  logic               benc_rdy_i;
  logic [KeyLen-1:0]  benc_key_o;
  logic [BlkLen-1:0]  benc_v_o;
  logic [Cmd-1:0]     benc_cmd_o;
  logic [StateId-1:0] benc_id_o;
  logic               benc_ack_i;
  logic               benc_rdy_o;
  logic [Cmd-1:0]     benc_cmd_i;
  logic [StateId-1:0] benc_id_i;
  logic [BlkLen-1:0]  benc_v_i;
  logic               quiet_o;
  logic [1:0]         err_o;

  modport slave (
    input  enable_i, c0_req_i, c1_req_i, c0_key_i, c1_key_i, c0_v_i, c1_v_i,
           c0_cmd_i, c1_cmd_i, c0_id_i, c1_id_i, c0_rdy_i, c1_rdy_i,
           benc_rdy_i, benc_ack_i, benc_cmd_i, benc_id_i, benc_v_i,
    output c0_rdy_o, c1_rdy_o, c0_ack_o, c1_ack_o, res_v_o, res_cmd_o, res_id_o,
           benc_req_o, benc_key_o, benc_v_o, benc_cmd_o, benc_id_o, benc_rdy_o,
           quiet_o, err_o
  );

  modport master (
    output enable_i, c0_req_i, c1_req_i, c0_key_i, c1_key_i, c0_v_i, c1_v_i,
           c0_cmd_i, c1_cmd_i, c0_id_i, c1_id_i, c0_rdy_i, c1_rdy_i,
           benc_rdy_i, benc_ack_i, benc_cmd_i, benc_id_i, benc_v_i,
    input  c0_rdy_o, c1_rdy_o, c0_ack_o, c1_ack_o, res_v_o, res_cmd_o, res_id_o,
           benc_req_o, benc_key_o, benc_v_o, benc_cmd_o, benc_id_o, benc_rdy_o,
           quiet_o, err_o
  );
endinterface

// File: rtl/csrng_blkenc_client_arb.sv
// Round-robin arbiter between the update (client 0) and generate (client 1)
// units in front of the block-encrypt engine; one transaction in flight.
module csrng_blkenc_client_arb #(
  parameter int Cmd     = 3,
  parameter int StateId = 4,
  parameter int BlkLen  = 128,
  parameter int KeyLen  = 256
) (
  input logic clk_i,
  input logic rst_i,
  csrng_blkenc_client_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  state_e             state_r, state_s;
  logic               grant_r, rr_r;
  logic [KeyLen-1:0]  key_r;
  logic [BlkLen-1:0]  v_r;
  logic [Cmd-1:0]     cmd_r;
  logic [StateId-1:0] id_r;
  logic [BlkLen-1:0]  res_v_r;
  logic [Cmd-1:0]     res_cmd_r;
  logic [StateId-1:0] res_id_r;
  logic [1:0]         err_r;

  logic gnt_s, accept_s, benc_hs_s, ack_hs_s, rsp_hs_s;

  // Grant selection: pointer only matters when both clients request.
  always_comb begin
    gnt_s = 1'b0;
    if (bus.c0_req_i && bus.c1_req_i) begin
      gnt_s = rr_r;
    end else if (bus.c0_req_i) begin
      gnt_s = 1'b0;
    end else begin
      gnt_s = 1'b1;
    end
  end

  assign accept_s  = bus.enable_i && (state_r == IDLE) && (bus.c0_req_i || bus.c1_req_i);
  assign benc_hs_s = (state_r == REQ) && bus.benc_rdy_i;
  assign ack_hs_s  = (state_r == WAIT) && bus.benc_ack_i;
  assign rsp_hs_s  = (state_r == RSP) && (grant_r ? bus.c1_rdy_i : bus.c0_rdy_i);

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and handshake outputs; a low enable forces IDLE.
  always_comb begin
    state_s        = state_r;
    bus.c0_rdy_o   = 1'b0;
    bus.c1_rdy_o   = 1'b0;
    bus.c0_ack_o   = 1'b0;
    bus.c1_ack_o   = 1'b0;
    bus.benc_req_o = 1'b0;
    bus.benc_rdy_o = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          bus.c0_rdy_o = !gnt_s;
          bus.c1_rdy_o = gnt_s;
          state_s      = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        bus.benc_req_o = 1'b1;
        if (benc_hs_s) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        bus.benc_rdy_o = 1'b1;
        if (ack_hs_s) begin
          state_s = RSP;
        end else begin
          state_s = WAIT;
        end
      end
      RSP: begin
        bus.c0_ack_o = !grant_r;
        bus.c1_ack_o = grant_r;
        if (rsp_hs_s) begin
          state_s = IDLE;
        end else begin
          state_s = RSP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    if (!bus.enable_i) begin
      state_s = IDLE;
    end else begin
      state_s = state_s;
    end
  end

  // Request, result and arbitration registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_r   <= 1'b0;
      rr_r      <= 1'b0;
      key_r     <= '0;
      v_r       <= '0;
      cmd_r     <= '0;
      id_r      <= '0;
      res_v_r   <= '0;
      res_cmd_r <= '0;
      res_id_r  <= '0;
    end else if (!bus.enable_i) begin
      grant_r   <= 1'b0;
      key_r     <= '0;
      v_r       <= '0;
      cmd_r     <= '0;
      id_r      <= '0;
      res_v_r   <= '0;
      res_cmd_r <= '0;
      res_id_r  <= '0;
    end else begin
      if (accept_s) begin
        grant_r <= gnt_s;
        rr_r    <= !gnt_s;
        key_r   <= gnt_s ? bus.c1_key_i : bus.c0_key_i;
        v_r     <= gnt_s ? bus.c1_v_i   : bus.c0_v_i;
        cmd_r   <= gnt_s ? bus.c1_cmd_i : bus.c0_cmd_i;
        id_r    <= gnt_s ? bus.c1_id_i  : bus.c0_id_i;
      end
      // The key is not kept once the engine has it.
      if (benc_hs_s) begin
        key_r <= '0;
      end
      if (ack_hs_s) begin
        res_v_r   <= bus.benc_v_i;
        res_cmd_r <= bus.benc_cmd_i;
        res_id_r  <= bus.benc_id_i;
      end
      if (rsp_hs_s) begin
        v_r       <= '0;
        res_v_r   <= '0;
        res_cmd_r <= '0;
        res_id_r  <= '0;
      end
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 2'b00;
    end else begin
      if (bus.benc_ack_i && (state_r != WAIT)) begin
        err_r[0] <= 1'b1;
      end
      if (ack_hs_s && bus.enable_i &&
          ((bus.benc_cmd_i != cmd_r) || (bus.benc_id_i != id_r))) begin
        err_r[1] <= 1'b1;
      end
    end
  end

  assign bus.benc_key_o = (state_r == REQ) ? key_r : '0;
  assign bus.benc_v_o   = (state_r == REQ) ? v_r   : '0;
  assign bus.benc_cmd_o = (state_r == REQ) ? cmd_r : '0;
  assign bus.benc_id_o  = (state_r == REQ) ? id_r  : '0;
  assign bus.res_v_o    = (state_r == RSP) ? res_v_r   : '0;
  assign bus.res_cmd_o  = (state_r == RSP) ? res_cmd_r : '0;
  assign bus.res_id_o   = (state_r == RSP) ? res_id_r  : '0;
  assign bus.quiet_o    = (state_r == IDLE);
  assign bus.err_o      = err_r;

endmodule

// File: tb/tb_csrng_blkenc_client_arb.sv
// Directed bench for the block-encrypt client arbiter with hand-computed
// expectations for grant order, routing, backpressure, errors and flush.
module tb_csrng_blkenc_client_arb;

  localparam logic [255:0] K0 = 256'h00112233445566778899aabbccddeeff_0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [255:0] K1 = 256'hfedcba9876543210fedcba9876543210_deadbeefcafef00d0123456789abcdef;
  localparam logic [127:0] V0 = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] V1 = 128'h13579bdf02468ace13579bdf02468ace;
  localparam logic [127:0] R0 = 128'haaaaaaaaaaaaaaaaaaaaaaaaaaaaaaaa;
  localparam logic [127:0] R1 = 128'h55555555555555555555555555555555;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  csrng_blkenc_client_arb_if bus ();

  csrng_blkenc_client_arb dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // One full transaction; g is the client the arbiter is expected to grant.
  task automatic do_txn(input logic r0, input logic r1, input logic g,
                        input int req_stall, input int rsp_stall,
                        input logic bad_id, input logic [1:0] exp_err);
    logic [255:0] ek;
    logic [127:0] ev, er;
    logic [2:0]   ec;
    logic [3:0]   ei, ri;
    ek = g ? K1 : K0;
    ev = g ? V1 : V0;
    er = g ? R1 : R0;
    ec = g ? 3'd3 : 3'd2;
    ei = g ? 4'd9 : 4'd5;
    ri = bad_id ? ei + 4'd1 : ei;
    bus.c0_req_i   = r0;
    bus.c1_req_i   = r1;
    bus.benc_rdy_i = (req_stall == 0);
    #1;
    check_val("idle_c0_rdy", 256'(bus.c0_rdy_o), 256'(!g));
    check_val("idle_c1_rdy", 256'(bus.c1_rdy_o), 256'(g));
    tick;
    for (int i = 0; i <= req_stall; i++) begin
      bus.benc_rdy_i = (i == req_stall);
      #1;
      check_val("req_benc_req", 256'(bus.benc_req_o), 256'(1'b1));
      check_val("req_key", bus.benc_key_o, ek);
      check_val("req_v", 256'(bus.benc_v_o), 256'(ev));
      check_val("req_cmd", 256'(bus.benc_cmd_o), 256'(ec));
      check_val("req_id", 256'(bus.benc_id_o), 256'(ei));
      check_val("req_no_rdy", 256'({bus.c0_rdy_o, bus.c1_rdy_o}), 256'(2'b00));
      check_val("req_quiet", 256'(bus.quiet_o), 256'(1'b0));
      tick;
    end
    bus.benc_rdy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("wait_benc_req", 256'(bus.benc_req_o), 256'(1'b0));
      check_val("wait_benc_rdy", 256'(bus.benc_rdy_o), 256'(1'b1));
      check_val("wait_acks", 256'({bus.c0_ack_o, bus.c1_ack_o}), 256'(2'b00));
      tick;
    end
    bus.benc_ack_i = 1'b1;
    bus.benc_v_i   = er;
    bus.benc_cmd_i = ec;
    bus.benc_id_i  = ri;
    tick;
    bus.benc_ack_i = 1'b0;
    bus.benc_v_i   = '0;
    bus.benc_cmd_i = 3'd0;
    bus.benc_id_i  = 4'd0;
    for (int i = 0; i <= rsp_stall; i++) begin
      bus.c0_rdy_i = g ? 1'b1 : (i == rsp_stall);
      bus.c1_rdy_i = g ? (i == rsp_stall) : 1'b1;
      #1;
      check_val("rsp_c0_ack", 256'(bus.c0_ack_o), 256'(!g));
      check_val("rsp_c1_ack", 256'(bus.c1_ack_o), 256'(g));
      check_val("rsp_v", 256'(bus.res_v_o), 256'(er));
      check_val("rsp_cmd", 256'(bus.res_cmd_o), 256'(ec));
      check_val("rsp_id", 256'(bus.res_id_o), 256'(ri));
      check_val("rsp_err", 256'(bus.err_o), 256'(exp_err));
      check_val("rsp_benc_rdy", 256'(bus.benc_rdy_o), 256'(1'b0));
      check_val("rsp_no_rdy", 256'({bus.c0_rdy_o, bus.c1_rdy_o}), 256'(2'b00));
      tick;
    end
    bus.c0_rdy_i = 1'b0;
    bus.c1_rdy_i = 1'b0;
    #1;
    check_val("end_quiet", 256'(bus.quiet_o), 256'(1'b1));
    check_val("end_acks", 256'({bus.c0_ack_o, bus.c1_ack_o}), 256'(2'b00));
    check_val("end_res_v", 256'(bus.res_v_o), 256'(0));
  endtask

  initial begin
    bus.enable_i   = 1'b0;
    bus.c0_req_i   = 1'b0;
    bus.c1_req_i   = 1'b0;
    bus.c0_key_i   = K0;
    bus.c1_key_i   = K1;
    bus.c0_v_i     = V0;
    bus.c1_v_i     = V1;
    bus.c0_cmd_i   = 3'd2;
    bus.c1_cmd_i   = 3'd3;
    bus.c0_id_i    = 4'd5;
    bus.c1_id_i    = 4'd9;
    bus.c0_rdy_i   = 1'b0;
    bus.c1_rdy_i   = 1'b0;
    bus.benc_rdy_i = 1'b0;
    bus.benc_ack_i = 1'b0;
    bus.benc_cmd_i = 3'd0;
    bus.benc_id_i  = 4'd0;
    bus.benc_v_i   = '0;

    #3;
    check_val("rst_quiet", 256'(bus.quiet_o), 256'(1'b1));
    check_val("rst_benc_req", 256'(bus.benc_req_o), 256'(1'b0));
    check_val("rst_benc_rdy", 256'(bus.benc_rdy_o), 256'(1'b0));
    check_val("rst_err", 256'(bus.err_o), 256'(2'b00));
    check_val("rst_acks", 256'({bus.c0_ack_o, bus.c1_ack_o}), 256'(2'b00));
    check_val("rst_res_v", 256'(bus.res_v_o), 256'(0));
    tick;
    rst = 1'b0;
    bus.enable_i = 1'b1;
    tick;

    // Contention: pointer starts on client 0 and alternates.
    do_txn(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00);
    do_txn(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 2'b00);
    do_txn(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 2'b00);
    do_txn(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 2'b00);
    // Single requester, then again with the pointer favouring client 1.
    do_txn(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 2'b00);
    do_txn(1'b1, 1'b0, 1'b0, 5, 3, 1'b0, 2'b00);
    // Engine returns id 6 for issued id 5.
    do_txn(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 2'b10);
    bus.c0_req_i = 1'b0;
    bus.c1_req_i = 1'b0;
    tick;

    bus.benc_ack_i = 1'b1;
    tick;
    bus.benc_ack_i = 1'b0;
    #1;
    check_val("uack_err", 256'(bus.err_o), 256'(2'b11));
    check_val("uack_quiet", 256'(bus.quiet_o), 256'(1'b1));
    check_val("uack_benc_req", 256'(bus.benc_req_o), 256'(1'b0));
    tick;

    bus.c0_req_i   = 1'b1;
    bus.benc_rdy_i = 1'b1;
    tick;
    bus.c0_req_i = 1'b0;
    tick;
    bus.benc_rdy_i = 1'b0;
    #1;
    check_val("flush_in_wait", 256'(bus.benc_rdy_o), 256'(1'b1));
    bus.enable_i = 1'b0;
    tick;
    check_val("flush_quiet", 256'(bus.quiet_o), 256'(1'b1));
    check_val("flush_benc_rdy", 256'(bus.benc_rdy_o), 256'(1'b0));
    check_val("flush_benc_req", 256'(bus.benc_req_o), 256'(1'b0));
    check_val("flush_acks", 256'({bus.c0_ack_o, bus.c1_ack_o}), 256'(2'b00));
    check_val("flush_res_v", 256'(bus.res_v_o), 256'(0));
    check_val("flush_err_kept", 256'(bus.err_o), 256'(2'b11));
    bus.enable_i = 1'b1;
    tick;

    bus.c0_req_i = 1'b1;
    tick;
    bus.c0_req_i = 1'b0;
    #1;
    check_val("mid_req", 256'(bus.benc_req_o), 256'(1'b1));
    rst = 1'b1;
    #1;
    check_val("arst_benc_req", 256'(bus.benc_req_o), 256'(1'b0));
    check_val("arst_quiet", 256'(bus.quiet_o), 256'(1'b1));
    check_val("arst_err", 256'(bus.err_o), 256'(2'b00));
    check_val("arst_key", bus.benc_key_o, 256'(0));
    tick;
    rst = 1'b0;
    tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csrng_blkenc_client_arb.md
Name: csrng_blkenc_client_arb

Overview:
Requester-side front end for the CSRNG AES block-encrypt engine. Arbitrates block-encrypt requests from the two CTR_DRBG clients: client 0 is update, client 1 is generate. Issues one request at a time over the engine's req/rdy + ack/rdy handshake and routes the returned cipher block, cmd and id back to the originating client. It sits between the ctr_drbg update/generate units and the block-encrypt engine, whose tracking FIFO holds exactly one outstanding request.

Parameters:
Cmd, 3, width of command field
StateId, 4, width of instance id field
BlkLen, 128, cipher block width
KeyLen, 256, AES key width

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
enable_i  in  1  module enable; low = synchronous flush to IDLE
c0_req_i / c1_req_i  in  1 each  client request valid
c0_rdy_o / c1_rdy_o  out  1 each  client request accepted this cycle
c0_key_i / c1_key_i  in  KeyLen each  client key
c0_v_i / c1_v_i  in  BlkLen each  client V block
c0_cmd_i / c1_cmd_i  in  Cmd each  client command
c0_id_i / c1_id_i  in  StateId each  client instance id
c0_ack_o / c1_ack_o  out  1 each  result valid for that client
c0_rdy_i / c1_rdy_i  in  1 each  client ready for result
res_v_o  out  BlkLen  result cipher block (shared)
res_cmd_o  out  Cmd  result command (shared)
res_id_o  out  StateId  result id (shared)
benc_req_o  out  1  request to engine
benc_rdy_i  in  1  engine ready to accept
benc_key_o  out  KeyLen  key to engine
benc_v_o  out  BlkLen  V to engine
benc_cmd_o  out  Cmd  command to engine
benc_id_o  out  StateId  id to engine
benc_ack_i  in  1  engine result valid
benc_rdy_o  out  1  ready for engine result
benc_cmd_i  in  Cmd  returned command
benc_id_i  in  StateId  returned id
benc_v_i  in  BlkLen  returned cipher block
quiet_o  out  1  high when FSM in IDLE
err_o  out  2  sticky errors: [0] unexpected ack, [1] cmd/id mismatch

Behaviour:
- Reset (rst_i high, async): FSM=IDLE. All data registers, rr pointer (favours client 0) and err_o cleared. All outputs 0 except quiet_o=1.
- FSM states: IDLE, REQ, WAIT, RSP. Only one transaction is outstanding at any time.
- IDLE:
  - If enable_i and any cX_req_i: grant one client; cX_rdy_o=1 combinationally for the granted client only.
  - Register key, v, cmd, id and the grant index; next state REQ.
  - Both requesting: grant the client favoured by the rr pointer; the pointer then favours the other client.
  - Single requester: granted regardless of pointer; pointer then favours the other client.
- REQ:
  - benc_req_o=1; benc_* driven from registers, stable until transfer.
  - Transfer on benc_req_o && benc_rdy_i: key register wiped to 0; next state WAIT.
  - Latency: client accept at cycle N gives benc_req_o high at N+1.
- WAIT:
  - benc_rdy_o=1; all other states drive benc_rdy_o=0.
  - On benc_ack_i: capture benc_v_i, benc_cmd_i, benc_id_i into result registers; next state RSP.
  - If the returned cmd/id differ from the issued cmd/id, set err_o[1]; the result is still delivered.
- RSP:
  - cX_ack_o=1 for the granted client only; res_* driven from result registers.
  - Transfer on cX_ack_o && cX_rdy_i: result registers and the v register cleared; next state IDLE.
  - A new client request can be accepted on the following cycle, not the same one.
- benc_ack_i in IDLE, REQ or RSP: set err_o[0]; ack is ignored and no state change occurs.
- enable_i low in any state: next cycle FSM=IDLE, all data registers cleared, no outputs asserted; err_o retained.
  - Any in-flight engine result is dropped. The engine's FIFO is cleared by the same enable.
- err_o bits are sticky until rst_i.
- res_* outputs read 0 outside RSP.
- Combinational paths: cX_rdy_o depends on cX_req_i; no other combinational path from input to output.

Test Plan:
- Single: c0 req key=K, v=0x0123..ef, cmd=2, id=5; engine rdy_i immediate, ack 3 cycles later with v=0xAA..AA, cmd=2, id=5.
  -> benc_req_o at N+1; c0_ack_o with res_v_o=0xAA..AA, res_cmd_o=2, res_id_o=5; c1_ack_o never asserted; err_o=0.
- Contention: c0 and c1 request continuously for 4 transactions.
  -> grants in order 0,1,0,1; each result routed to the matching client.
- Backpressure: benc_rdy_i held low 5 cycles, then c0_rdy_i held low 3 cycles in RSP.
  -> benc_* stable throughout REQ; result held stable in RSP; exactly one transfer per stage.
- Mismatch: engine returns id=6 for issued id=5.
  -> err_o=2'b10, result still delivered to client.
- Unexpected ack: benc_ack_i pulsed while in IDLE.
  -> err_o[0]=1, FSM stays IDLE.
- Flush and reset: drop enable_i in WAIT.
  -> next cycle IDLE, quiet_o=1, all outputs 0.
  - Then assert rst_i mid-REQ -> immediate IDLE, benc_req_o=0, err_o=0.
